i2c_init_sequencer: RTL and testbench
=====================================

I2C_INIT_SEQUENCER -- requirements
Module: i2c_init_sequencer

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h3C, the 7-bit target device address.
REQ-002 SHALL have parameter N_ENTRIES, default 3, the number of register-write entries in the internal table.
REQ-003 SHALL have parameter GAP_CYCLES, default 100, the idle clk cycles between consecutive entries.
REQ-004 SHALL have parameter MAX_RETRY, default 2, the extra attempts per entry after a NACK.
REQ-005 SHALL have clk  input  1  system clock; all state changes on the rising edge.
REQ-006 SHALL have rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have start  input  1  single-cycle request to run the whole table.
REQ-008 SHALL have busy  output  1  high while a table run is in progress.
REQ-009 SHALL have done  output  1  one-cycle pulse when all entries complete with ACK.
REQ-010 SHALL have error  output  1  sticky flag for an entry that failed after MAX_RETRY retries.
REQ-011 SHALL have cmd_valid  output  1  byte command offered to the downstream I2C byte master.
REQ-012 SHALL have cmd_ready  input  1  downstream accepts the command.
REQ-013 SHALL have cmd_start  output  1  generate START before this byte.
REQ-014 SHALL have cmd_stop  output  1  generate STOP after this byte's ACK slot.
REQ-015 SHALL have cmd_data  output  8  byte to transmit MSB-first.
REQ-016 SHALL have rsp_valid  input  1  one-cycle pulse: the byte's ACK slot is finished.
REQ-017 SHALL have rsp_ack  input  1  qualified by rsp_valid; 1 = ACK (SDA low), 0 = NACK.

Function
REQ-018 SHALL hold a constant table of N_ENTRIES {reg_addr[7:0], data[7:0]} pairs; the default contents are {8'h00,8'h0A}, {8'h01,8'h19}, {8'h02,8'h3C}.
REQ-019 SHALL implement states IDLE, SEND_ADDR, SEND_REG, SEND_DATA, WAIT_RSP, GAP, FAIL.
REQ-020 SHALL in IDLE move to SEND_ADDR on start=1, with entry index 0, retry count 0, and error cleared.
REQ-021 SHALL ignore start while busy=1.
REQ-022 SHALL in SEND_ADDR present cmd_data={DEV_ADDR,1'b0}, cmd_start=1, cmd_stop=0.
REQ-023 SHALL in SEND_REG present cmd_data=reg_addr[index], cmd_start=0, cmd_stop=0.
REQ-024 SHALL in SEND_DATA present cmd_data=data[index], cmd_start=0, cmd_stop=1.
REQ-025 SHALL assert cmd_valid in the SEND_* states and keep cmd_data, cmd_start and cmd_stop stable until the cycle where cmd_valid and cmd_ready are both 1.
REQ-026 SHALL treat that cycle as the transfer and enter WAIT_RSP on the next cycle with cmd_valid=0.
REQ-027 SHALL issue exactly one command per WAIT_RSP.
REQ-028 SHALL in WAIT_RSP ignore rsp_valid pulses arriving in any other state.
REQ-029 SHALL on rsp_valid=1 with rsp_ack=1 advance SEND_ADDR->SEND_REG->SEND_DATA, and after SEND_DATA go to GAP.
REQ-030 SHALL on rsp_valid=1 with rsp_ack=0 increment the retry count and restart the same entry at SEND_ADDR after GAP; the downstream master itself issues STOP after a NACK.
REQ-031 SHALL, when a NACK occurs with retry count already equal to MAX_RETRY, go to FAIL, set error=1, and drop busy.
REQ-032 SHALL in GAP count GAP_CYCLES cycles and then go to SEND_ADDR for the next or retried entry.
REQ-033 SHALL, when the last entry succeeded, go directly from SEND_DATA's ACK to IDLE, pulse done for one cycle, and drop busy in that same cycle.
REQ-034 SHALL reset the retry count to 0 on each new entry.
REQ-035 SHALL size the index and counters with $clog2 of their maximum values; no wrap beyond N_ENTRIES-1 is permitted.
REQ-036 SHALL keep busy=1 in every state except IDLE and FAIL.
REQ-037 SHALL in FAIL accept start as in IDLE, which clears error.
REQ-038 SHALL treat simultaneous start and done as a restart: done pulses and the new run begins next cycle.

Reset
REQ-039 SHALL on rst=1 immediately enter IDLE with busy=0, done=0, error=0, cmd_valid=0, cmd_start=0, cmd_stop=0, cmd_data=8'h00, and index, retry and gap counters at 0.
REQ-040 SHALL allow reset mid-transaction to drop cmd_valid without completing the handshake; the downstream block is reset by the same rst.

Verification
REQ-041 SHALL pass: start with an always-ACK responder -> bytes 78,00,0A / 78,01,19 / 78,02,3C with start on the first byte and stop on the third of each triple, then one done pulse and error=0.
REQ-042 SHALL pass: cmd_ready held low 5 cycles on the second byte -> cmd_data stays 00 and cmd_valid stays 1 throughout, with no duplicate byte.
REQ-043 SHALL pass: NACK on the first address byte of entry 1 -> entry 1 is resent after a GAP of 100 cycles and the run completes with done.
REQ-044 SHALL pass: 3 consecutive NACKs on entry 0 -> error=1 and busy=0, no entry-1 bytes are sent, and a later start clears error.
REQ-045 SHALL pass: rst asserted while in WAIT_RSP -> all outputs reach their reset values before the next clk edge, and a spurious rsp_valid afterwards has no effect.
REQ-046 SHALL pass: start pulsed while busy -> ignored and the sequence is unchanged.

Source files
------------

// File: rtl/i2c_init_sequencer.sv
// Plays a fixed table of register writes to one I2C device through a byte-level
// master: START+addr, reg, data+STOP per entry, with idle gaps and bounded retries.
module i2c_init_sequencer #(
  parameter logic [6:0]                 DEV_ADDR   = 7'h3C,
  parameter int                         N_ENTRIES  = 3,
  parameter int                         GAP_CYCLES = 100,  // must be >= 1
  parameter int                         MAX_RETRY  = 2,
  parameter logic [N_ENTRIES-1:0][15:0] TABLE      = {16'h023C, 16'h0119, 16'h000A}
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_start,
  output logic       cmd_stop,
  output logic [7:0] cmd_data,
  input  logic       rsp_valid,
  input  logic       rsp_ack
);
  localparam int IDX_W = (N_ENTRIES > 1)  ? $clog2(N_ENTRIES)     : 1;
  localparam int RTY_W = (MAX_RETRY > 0)  ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES)    : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_ENTRIES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       ADDR_BYTE = {DEV_ADDR, 1'b0};

  typedef enum logic [2:0] {
    IDLE, SEND_ADDR, SEND_REG, SEND_DATA, WAIT_RSP, GAP, FAIL
  } state_e;

  // Which byte of the triple is outstanding while sitting in WAIT_RSP.
  typedef enum logic [1:0] {PH_ADDR, PH_REG, PH_DATA} phase_e;

  state_e           state_q;
  phase_e           phase_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             busy_q, done_q, error_q;
  logic             cmd_valid_q, cmd_start_q, cmd_stop_q;
  logic [7:0]       cmd_data_q;
  logic [15:0]      entry;

  assign entry = TABLE[idx_q];

  always_comb begin
    idx_d = idx_q + 1'b1;
    rty_d = rty_q + 1'b1;
    gap_d = gap_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= PH_ADDR;
      idx_q       <= '0;
      rty_q       <= '0;
      gap_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_start_q <= 1'b0;
      cmd_stop_q  <= 1'b0;
      cmd_data_q  <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, FAIL: begin
          if (start) begin
            state_q     <= SEND_ADDR;
            phase_q     <= PH_ADDR;
            idx_q       <= '0;
            rty_q       <= '0;
            error_q     <= 1'b0;
            busy_q      <= 1'b1;
            cmd_valid_q <= 1'b1;
            cmd_start_q <= 1'b1;
            cmd_stop_q  <= 1'b0;
            cmd_data_q  <= ADDR_BYTE;
          end
        end
        SEND_ADDR, SEND_REG, SEND_DATA: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_valid) begin
            if (rsp_ack) begin
              case (phase_q)
                PH_ADDR: begin
                  state_q     <= SEND_REG;
                  phase_q     <= PH_REG;
                  cmd_valid_q <= 1'b1;
                  cmd_start_q <= 1'b0;
                  cmd_stop_q  <= 1'b0;
                  cmd_data_q  <= entry[15:8];
                end
                PH_REG: begin
                  state_q     <= SEND_DATA;
                  phase_q     <= PH_DATA;
                  cmd_valid_q <= 1'b1;
                  cmd_start_q <= 1'b0;
                  cmd_stop_q  <= 1'b1;
                  cmd_data_q  <= entry[7:0];
                end
                default: begin
                  if (idx_q == LAST_IDX) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                  end else begin
                    state_q <= GAP;
                    idx_q   <= idx_d;
                    rty_q   <= '0;
                    gap_q   <= '0;
                  end
                end
              endcase
            end else if (rty_q == RTY_MAX) begin
              state_q <= FAIL;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              // The byte master already closed the bus with STOP on the NACK.
              rty_q   <= rty_d;
              state_q <= GAP;
              gap_q   <= '0;
            end
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q     <= SEND_ADDR;
            phase_q     <= PH_ADDR;
            cmd_valid_q <= 1'b1;
            cmd_start_q <= 1'b1;
            cmd_stop_q  <= 1'b0;
            cmd_data_q  <= ADDR_BYTE;
          end else begin
            gap_q <= gap_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_start = cmd_start_q;
  assign cmd_stop  = cmd_stop_q;
  assign cmd_data  = cmd_data_q;
endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Scoreboard bench: a byte-stream model predicts every command; a randomized
// responder ACKs/NACKs per a plan and a separate monitor checks each transfer.
module tb_i2c_init_sequencer;
  localparam int         N      = 3;
  localparam int         GAP    = 100;
  localparam int         MAXR   = 2;
  localparam logic [7:0] ADDR_B = 8'h78;

  logic       clk = 1'b0;
  logic       rst, start, busy, done, error;
  logic       cmd_valid, cmd_ready, cmd_start, cmd_stop;
  logic [7:0] cmd_data;
  logic       rsp_valid, rsp_ack;

  always #5 clk = ~clk;

  i2c_init_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start),
    .cmd_stop(cmd_stop), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack)
  );

  typedef struct {
    logic       st;
    logic       sp;
    logic [7:0] d;
    int         gap;   // idle cycles before this byte; -1 = not checked
  } exp_t;

  logic [7:0] REG_T [N] = '{8'h00, 8'h01, 8'h02};
  logic [7:0] DAT_T [N] = '{8'h0A, 8'h19, 8'h3C};

  exp_t exp_q[$];
  bit   ack_plan[$];
  int   total = 0, bad = 0;
  int   xfer_cnt = 0, hold_at = -1, hold = 0, rsp_dly = 0, spurious = 0;
  bit   pend_ack, xr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Byte stream a run must produce for a given per-byte ACK plan; outcome 1=done, 2=fail.
  task automatic push_run(input bit plan[$], output int outcome);
    int e = 0, k = 0, rty = 0, bi = 0;
    bit first = 1'b1, ack;
    exp_t x;
    outcome = 1;
    while (e < N) begin
      x.st  = (k == 0);
      x.sp  = (k == 2);
      x.d   = (k == 0) ? ADDR_B : (k == 1) ? REG_T[e] : DAT_T[e];
      x.gap = first ? -1 : ((k == 0) ? GAP : 0);
      first = 1'b0;
      exp_q.push_back(x);
      ack = (bi < plan.size()) ? plan[bi] : 1'b1;
      bi++;
      if (!ack) begin
        if (rty == MAXR) begin outcome = 2; return; end
        rty++;
        k = 0;
      end else if (k == 2) begin
        e++; k = 0; rty = 0;
      end else k++;
    end
  endtask

  // Responder: samples handshake at negedge, drives ready/response just after posedge.
  initial begin
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_ack = 1'b0;
    forever begin
      @(negedge clk);
      xr = cmd_valid && cmd_ready && !rst;
      @(posedge clk);
      #1;
      rsp_valid = 1'b0;
      if (rst) begin
        rsp_dly = 0; hold = 0; cmd_ready = 1'b0;
        continue;
      end
      if (xr) begin
        pend_ack = (ack_plan.size() > 0) ? ack_plan.pop_front() : 1'b1;
        rsp_dly  = $urandom_range(1, 3);
        xfer_cnt++;
      end
      if (rsp_dly > 0) begin
        rsp_dly--;
        if (rsp_dly == 0) begin rsp_valid = 1'b1; rsp_ack = pend_ack; end
      end else if (spurious != 0) begin
        rsp_valid = 1'b1; rsp_ack = 1'($urandom_range(0, 1)); spurious = 0;
      end
      if (hold_at >= 0 && cmd_valid && xfer_cnt == hold_at) begin hold = 5; hold_at = -1; end
      if (hold > 0) begin cmd_ready = 1'b0; hold--; end
      else cmd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks stall stability and gaps.
  bit         prev_hold = 0, counting = 0, ps, pp;
  logic [7:0] pd;
  int         idle = 0, meas_gap = 0;
  exp_t       ex;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin prev_hold = 0; counting = 0; continue; end
      if (prev_hold)
        check("hold_stable", {cmd_valid, cmd_start, cmd_stop, cmd_data}, {1'b1, ps, pp, pd});
      if (rsp_valid) begin counting = 1; idle = 0; end
      else if (counting) begin
        if (!busy) counting = 0;
        else if (cmd_valid) begin meas_gap = idle; counting = 0; end
        else idle++;
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_byte: got %02h want none", cmd_data);
        end else begin
          ex = exp_q.pop_front();
          check("byte", {cmd_start, cmd_stop, cmd_data}, {ex.st, ex.sp, ex.d});
          if (ex.gap >= 0) check("gap", meas_gap, ex.gap);
        end
      end
      prev_hold = cmd_valid && !cmd_ready;
      ps = cmd_start; pp = cmd_stop; pd = cmd_data;
    end
  end

  task automatic wait_end(input bit noise, output int res);
    res = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin res = 1; break; end
      if (error && !busy) begin res = 2; break; end
      if (noise && busy && $urandom_range(0, 15) == 0) start = 1'b1;
    end
    start = 1'b0;
    if (res == 0) $display("FAIL run_timeout: got no end want done or error");
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_cleared", error, 0);
  endtask

  task automatic run_one(input bit plan[$], input bit noise);
    int exp_o, res;
    push_run(plan, exp_o);
    ack_plan = plan;
    pulse_start();
    wait_end(noise, res);
    check("outcome", res, exp_o);
    if (res == 1) begin
      check("end_flags", {busy, error}, 2'b00);
      @(posedge clk); #1 check("done_one_cycle", done, 0);
    end else if (res == 2) check("fail_flags", {error, busy}, 2'b10);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete(); ack_plan.delete();
  endtask

  bit plan[$];
  int res, o, xc;
  bit found;
  initial begin
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("rst_outs", {busy, done, error, cmd_valid, cmd_start, cmd_stop, cmd_data}, 0);
    @(posedge clk); #1 rst = 1'b0;

    plan = {};                    run_one(plan, 0);     // all ACK
    xfer_cnt = 0; hold_at = 1;    run_one(plan, 0);     // stall on 2nd byte
    plan = {1, 1, 1, 0};          run_one(plan, 0);     // NACK entry 1 address
    xfer_cnt = 0; plan = {0, 0, 0};
    run_one(plan, 0);                                    // retries exhausted
    repeat (30) @(posedge clk);
    #1 check("no_bytes_after_fail", xfer_cnt, 3);
    check("fail_sticky", {error, busy, cmd_valid}, 3'b100);
    plan = {};                    run_one(plan, 0);     // restart clears error
    run_one(plan, 1);                                    // start noise while busy

    // Reset while waiting for a response, then a stray response.
    xfer_cnt = 0; push_run(plan, o);
    pulse_start();
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #2;
      if (xfer_cnt >= 1 && busy && !cmd_valid) begin found = 1; break; end
    end
    check("reached_wait_rsp", found, 1);
    #1 rst = 1'b1;
    #1 check("async_rst_outs", {busy, done, error, cmd_valid, cmd_start, cmd_stop, cmd_data}, 0);
    exp_q.delete(); ack_plan.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; xc = xfer_cnt; spurious = 1;
    repeat (10) @(posedge clk);
    #1 check("stray_rsp_ignored", {busy, done, error, cmd_valid}, 0);
    check("no_bytes_after_rst", xfer_cnt, xc);

    // Start coinciding with done restarts immediately.
    push_run(plan, o);
    pulse_start();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    check("done_seen", done, 1);
    check("busy_low_at_done", busy, 0);
    push_run(plan, o);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("restart_busy", busy, 1);
    wait_end(0, res);
    check("restart_outcome", res, 1);
    check("restart_drained", exp_q.size(), 0);
    exp_q.delete();

    for (int r = 0; r < 6; r++) begin
      plan = {};
      for (int i = 0; i < 12; i++) plan.push_back($urandom_range(0, 4) != 0);
      run_one(plan, 1);
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
